// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the RV32I multi-cycle control path.
//  - RV32I major opcodes (IR[6:0])
//  - sequencer state codes (state_t)
//  - control encodings: imm_sel, alu_op, alu_src_a, alu_src_b, result_src
package riscv_pkg;

   // Major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Sequencer states
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH   = 4'd0;
   localparam state_t S_DECODE  = 4'd1;
   localparam state_t S_EXEC_R  = 4'd2;
   localparam state_t S_EXEC_I  = 4'd3;
   localparam state_t S_WB_ALU  = 4'd4;
   localparam state_t S_MEMADDR = 4'd5;
   localparam state_t S_MEMRD   = 4'd6;
   localparam state_t S_MEMWR   = 4'd7;
   localparam state_t S_WB_MEM  = 4'd8;
   localparam state_t S_BRANCH  = 4'd9;
   localparam state_t S_JAL     = 4'd10;
   localparam state_t S_JALR    = 4'd11;
   localparam state_t S_LUI     = 4'd12;
   localparam state_t S_AUIPC   = 4'd13;
   localparam state_t S_ILLEGAL = 4'd14;
   localparam state_t S_TRAP    = 4'd15;

   // Immediate format select
   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_S    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;

   // ALU operation class
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   // ALU operand A / B sources
   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_RS1    = 2'b01;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
   localparam logic [1:0] SRC_A_ZERO   = 2'b11;
   localparam logic [1:0] SRC_B_RS2    = 2'b00;
   localparam logic [1:0] SRC_B_IMM    = 2'b01;
   localparam logic [1:0] SRC_B_FOUR   = 2'b10;

   // Register-file write data source
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC  = 2'b10;

endpackage

// File: rtl/mc_main_decoder.sv
// mc_main_decoder: combinational opcode decode for the multi-cycle sequencer.
//  op         in  7  IR[6:0]
//  next_state out 4  state entered after S_DECODE (S_ILLEGAL for unknown opcodes)
//  imm_sel    out 3  immediate format for this opcode
module mc_main_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] op,
   output state_t     next_state,
   output logic [2:0] imm_sel
);

   always_comb begin
      next_state = S_ILLEGAL;
      imm_sel    = IMM_NONE;
      case (op)
         OP_R:      begin next_state = S_EXEC_R;  imm_sel = IMM_NONE; end
         OP_I:      begin next_state = S_EXEC_I;  imm_sel = IMM_I;    end
         OP_LOAD:   begin next_state = S_MEMADDR; imm_sel = IMM_I;    end
         OP_STORE:  begin next_state = S_MEMADDR; imm_sel = IMM_S;    end
         OP_BRANCH: begin next_state = S_BRANCH;  imm_sel = IMM_B;    end
         OP_JAL:    begin next_state = S_JAL;     imm_sel = IMM_J;    end
         OP_JALR:   begin next_state = S_JALR;    imm_sel = IMM_I;    end
         OP_LUI:    begin next_state = S_LUI;     imm_sel = IMM_U;    end
         OP_AUIPC:  begin next_state = S_AUIPC;   imm_sel = IMM_U;    end
         default:   begin next_state = S_ILLEGAL; imm_sel = IMM_NONE; end
      endcase
   end

endmodule

// File: rtl/riscv_mc_sequencer.sv
// riscv_mc_sequencer: control FSM for the RV32I multi-cycle core. Sequences the shared ALU
// and unified memory through fetch/decode/execute/mem/writeback and counts retirements.
//  clk, rst (async, active-high)
//  op, branch_cond, mem_ready                  inputs from datapath / memory
//  mem_req, mem_we, addr_sel                   memory control
//  ir_write, pc_write, pc_src, reg_write       datapath write enables / PC source
//  alu_src_a, alu_src_b, alu_op, result_src,
//  imm_sel                                     datapath steering
//  instr_done, instret                         commit pulse and retired count (CNT_W bits)
//  illegal_op                                  sticky illegal-opcode flag
// Build option: RISCV_ILLEGAL_TRAP_EN traps on unknown opcodes (otherwise they retire as NOPs).
module riscv_mc_sequencer
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic             branch_cond,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic [2:0]       imm_sel,
   output logic             instr_done,
   output logic [CNT_W-1:0] instret,
   output logic             illegal_op
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   state_t           dec_next;
   logic [2:0]       dec_imm;

   mc_main_decoder u_dec (
      .op         (op),
      .next_state (dec_next),
      .imm_sel    (dec_imm)
   );

`ifdef RISCV_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_ADD;
      result_src = RES_ALU;
      instr_done = 1'b0;
`ifdef RISCV_ILLEGAL_TRAP_EN
      illegal_d  = illegal_q;
`endif
      // op is only meaningful once the IR holds the fetched word
      imm_sel    = (state_q == S_FETCH || state_q == S_TRAP) ? IMM_NONE : dec_imm;

      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         // Speculatively form the branch/jump target in ALUOut
         S_DECODE: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            state_d   = dec_next;
         end
         S_EXEC_R: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_FN;
            state_d   = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_FN;
            state_d   = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMADDR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            if (mem_ready) state_d = S_WB_MEM;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            result_src = RES_MEM;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         // Target sits in ALUOut while the ALU compares rs1/rs2
         S_BRANCH: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALU_BR;
            pc_src     = 1'b1;
            pc_write   = branch_cond;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            reg_write  = 1'b1;
            result_src = RES_PC;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            result_src = RES_PC;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_LUI: begin
            alu_src_a  = SRC_A_ZERO;
            alu_src_b  = SRC_B_IMM;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_AUIPC: begin
            alu_src_a  = SRC_A_OLD_PC;
            alu_src_b  = SRC_B_IMM;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ILLEGAL: begin
`ifdef RISCV_ILLEGAL_TRAP_EN
            illegal_d  = 1'b1;
            state_d    = S_TRAP;
`else
            instr_done = 1'b1;
            state_d    = S_FETCH;
`endif
         end
`ifdef RISCV_ILLEGAL_TRAP_EN
         // Dead end: only rst leaves the trap
         S_TRAP: state_d = S_TRAP;
`endif
         default: state_d = S_FETCH;
      endcase

      instret_d = instr_done ? instret_q + CNT_W'(1) : instret_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

`ifdef RISCV_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   assign instret = instret_q;

endmodule
